alu_seq_exec: RTL and testbench

- Multi-cycle integer execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder, plus two XLEN-bit operands.
- Returns the result and a zero flag over a valid/ready handshake.
- Logic/arithmetic/compare ops complete in one cycle. Shifts run serially, one bit position per cycle, to save area.
- Sits in the EX stage between the operand muxes and the writeback/branch logic.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_comb_core.sv | 37 +++
 rtl/alu_seq_exec.sv | 122 ++++++++++++
 tb/tb_alu_seq_exec.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// Shared ALU definitions: control codes, FSM state encoding, code classification helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // ALU control codes, shared with the ALU control decoder
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

    // Codes 1010..1111 are unassigned
    function automatic logic is_legal(input logic [3:0] code);
        return code <= ALU_SRA;
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
`timescale 1ns/1ps
// Single-cycle ALU ops: AND/OR/XOR/ADD/SUB/SLT/SLTU; shift and illegal codes yield 0.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
// Ports: ctrl (control code), op_a/op_b (operands), res (combinational result).
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] res
);

    logic slt_bit;
    logic sltu_bit;

    assign slt_bit  = $signed(op_a) < $signed(op_b);
    assign sltu_bit = op_a < op_b;

    always_comb begin
        res = '0;
        case (ctrl)
            ALU_AND:  res = op_a & op_b;
            ALU_OR:   res = op_a | op_b;
            ALU_XOR:  res = op_a ^ op_b;
            ALU_ADD:  res = op_a + op_b;
            ALU_SUB:  res = op_a - op_b;
            ALU_SLT:  res = {{(XLEN-1){1'b0}}, slt_bit};
            ALU_SLTU: res = {{(XLEN-1){1'b0}}, sltu_bit};
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
`timescale 1ns/1ps
// Multi-cycle EX unit: one-cycle logic/arith/compare, serial one-bit-per-cycle shifts.
// Latency: 1 cycle accept->out_valid; shifts take 1+shamt cycles.
// Backpressure: result held in DONE until out_ready; no accept outside IDLE (max 1 op / 2 cycles).
// Ports: clk/reset; in_valid/in_ready + ctrl/op_a/op_b request side;
//        out_valid/out_ready + result/zero/illegal response side.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    state_t            state;
    logic [XLEN-1:0]   result_q;
    logic              illegal_q;
    logic              out_valid_q;
    logic [SHW-1:0]    cnt;
    logic              shift_left;
    logic              shift_arith;

    logic [XLEN-1:0]   core_res;
    logic [XLEN-1:0]   shift_next;
    logic [SHW-1:0]    shamt;
    logic              fill_bit;

    alu_comb_core #(.XLEN(XLEN)) u_core (
        .ctrl (ctrl),
        .op_a (op_a),
        .op_b (op_b),
        .res  (core_res)
    );

    // Only the low SHW bits of op_b matter for shifts
    assign shamt = op_b[SHW-1:0];

    // Working register is the result register itself; SRA replicates the sign bit
    assign fill_bit   = shift_arith & result_q[XLEN-1];
    assign shift_next = shift_left ? {result_q[XLEN-2:0], 1'b0}
                                   : {fill_bit, result_q[XLEN-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            cnt         <= '0;
            shift_left  <= 1'b0;
            shift_arith <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        illegal_q <= !is_legal(ctrl);
                        if (!is_legal(ctrl)) begin
                            result_q    <= '0;
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end else if (is_shift(ctrl)) begin
                            result_q    <= op_a;
                            cnt         <= shamt;
                            shift_left  <= (ctrl == ALU_SLL);
                            shift_arith <= (ctrl == ALU_SRA);
                            if (shamt == '0) begin
                                out_valid_q <= 1'b1;
                                state       <= ST_DONE;
                            end else begin
                                state       <= ST_SHIFT;
                            end
                        end else begin
                            result_q    <= core_res;
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    result_q <= shift_next;
                    cnt      <= cnt - CNT_ONE;
                    // Counter hits zero with this step: the result is final
                    if (cnt == CNT_ONE) begin
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
`timescale 1ns/1ps
// Directed self-checking bench for alu_seq_exec.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low with a pending request.
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    alu_seq_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for a single accepting edge, then wait (bounded) for out_valid.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output int latency);
        ctrl     = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        latency  = 1;
        while (out_valid !== 1'b1 && latency < 64) begin
            chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
            step;
            latency++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ctrl      = 4'h0;
        op_a      = '0;
        op_b      = '0;
        step;
        step;
        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    result,             32'd0);
        chk("rst_illegal",   {31'd0, illegal},   32'd0);
        chk("rst_zero",      {31'd0, zero},      32'd1);
        #2 reset = 1'b0;
        step;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // ADD wraps to zero
        run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, lat);
        chk("add_lat",     lat,                32'd1);
        chk("add_result",  result,             32'h0);
        chk("add_zero",    {31'd0, zero},      32'd1);
        chk("add_illegal", {31'd0, illegal},   32'd0);
        chk("add_in_rdy",  {31'd0, in_ready},  32'd0);
        step;
        chk("add_ov_fall", {31'd0, out_valid}, 32'd0);
        chk("add_rdy_up",  {31'd0, in_ready},  32'd1);

        // SUB, SLT, SLTU
        run_op(4'b0110, 32'd5, 32'd7, lat);
        chk("sub_lat",    lat,           32'd1);
        chk("sub_result", result,        32'hFFFF_FFFE);
        chk("sub_zero",   {31'd0, zero}, 32'd0);
        step;
        run_op(4'b0111, 32'hFFFF_FFFE, 32'd1, lat);
        chk("slt_result", result, 32'd1);
        step;
        run_op(4'b1000, 32'hFFFF_FFFE, 32'd1, lat);
        chk("sltu_result", result,        32'd0);
        chk("sltu_zero",   {31'd0, zero}, 32'd1);
        step;

        // Logic ops
        run_op(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
        chk("and_result", result, 32'h00F0_00F0);
        step;
        run_op(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
        chk("or_result", result, 32'hFFF0_FFF0);
        step;
        run_op(4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
        chk("xor_result", result, 32'hFF00_FF00);
        step;

        // SRA by 3 (upper op_b bits ignored)
        run_op(4'b1001, 32'h8000_0000, 32'h0000_0023, lat);
        chk("sra_lat",    lat,    32'd4);
        chk("sra_result", result, 32'hF000_0000);
        step;
        chk("sra_rdy_up", {31'd0, in_ready}, 32'd1);

        // SLL with shamt 0 in low bits
        run_op(4'b0100, 32'h1234_5678, 32'h0000_0020, lat);
        chk("sll0_lat",    lat,    32'd1);
        chk("sll0_result", result, 32'h1234_5678);
        step;
        run_op(4'b0100, 32'h8000_0001, 32'd1, lat);
        chk("sll1_lat",    lat,    32'd2);
        chk("sll1_result", result, 32'h0000_0002);
        step;
        run_op(4'b0101, 32'hF000_000F, 32'd4, lat);
        chk("srl4_lat",    lat,    32'd5);
        chk("srl4_result", result, 32'h0F00_0000);
        step;

        // Backpressure: hold result while a competing request is presented
        out_ready = 1'b0;
        run_op(4'b0010, 32'd3, 32'd4, lat);
        chk("bp_result0", result, 32'd7);
        ctrl     = 4'b0000;
        op_a     = 32'hFFFF_FFFF;
        op_b     = 32'h0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result",    result,             32'd7);
            chk("bp_zero",      {31'd0, zero},      32'd0);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        chk("bp_ov_fall",  {31'd0, out_valid}, 32'd0);
        chk("bp_rdy_up",   {31'd0, in_ready},  32'd1);
        chk("bp_no_accept", result,            32'd7);
        step;
        chk("bp_no_ov",    {31'd0, out_valid}, 32'd0);

        // Illegal code, then cleared by the next accept
        run_op(4'b1100, 32'd5, 32'd5, lat);
        chk("ill_lat",     lat,              32'd1);
        chk("ill_result",  result,           32'd0);
        chk("ill_zero",    {31'd0, zero},    32'd1);
        chk("ill_flag",    {31'd0, illegal}, 32'd1);
        step;
        chk("ill_held",    {31'd0, illegal}, 32'd1);
        run_op(4'b0010, 32'd1, 32'd1, lat);
        chk("ill_clear",   {31'd0, illegal}, 32'd0);
        chk("ill_next_res", result,          32'd2);
        step;

        // Reset in the middle of an SRL by 20
        ctrl     = 4'b0101;
        op_a     = 32'hFFFF_FFFF;
        op_b     = 32'd20;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        repeat (4) step;
        chk("mid_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_partial",  result,            32'h0FFF_FFFF);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_result",    result,             32'd0);
        chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
        step;
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("post_rst_no_ov", {31'd0, out_valid}, 32'd0);
        end
        run_op(4'b0010, 32'd10, 32'd20, lat);
        chk("post_rst_lat", lat,    32'd1);
        chk("post_rst_res", result, 32'd30);
        step;
        chk("post_rst_idle", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
